// File: rtl/rv32_mtimer.sv
// Machine timer peripheral: 64-bit prescaled mtime, 64-bit mtimecmp and a level
// timer interrupt, exposed as six 32-bit registers behind a one-cycle ack bus.
module rv32_mtimer #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter logic [31:0] PRESCALE_RST = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rready_cpu,
    output logic        rvalid_cpu,
    input  logic        wvalid_cpu,
    output logic        wready_cpu,
    input  logic [3:0]  strb_cpu,
    input  logic [31:0] addr_cpu,
    input  logic [31:0] data_cpu_o,
    output logic [31:0] rdata_cpu,
    output logic        timer_irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RACK = 2'd1,
        S_WACK = 2'd2
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        hit_s, wr_s, rd_s, tick_s;
    logic [3:0]  wr_code_s;
    logic [31:0] rd_mux_s;

    logic [63:0] mtime_r, mtime_nxt_s;
    logic [63:0] mtimecmp_r, mtimecmp_nxt_s;
    logic        irq_en_r, irq_en_nxt_s;
    logic        cnt_en_r, cnt_en_nxt_s;
    logic [31:0] prescale_r, prescale_nxt_s;
    logic [31:0] pcnt_r, pcnt_nxt_s;

    logic        rvalid_r, wready_r, irq_r;
    logic [31:0] rdata_r;
    logic        unused_addr_s;

    assign hit_s         = (addr_cpu[31:5] == BASE_ADDR[31:5]);
    assign unused_addr_s = ^addr_cpu[1:0];
    assign tick_s        = cnt_en_r && (pcnt_r == prescale_r);
    // Only a committed write selects a register; 4'hF means no write this cycle.
    assign wr_code_s     = wr_s ? {1'b0, addr_cpu[4:2]} : 4'hF;

    // Bus FSM: a write beats a simultaneous read, and nothing is accepted while acking.
    always_comb begin
        state_nxt_s = S_IDLE;
        wr_s        = 1'b0;
        rd_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (hit_s && wvalid_cpu) begin
                    state_nxt_s = S_WACK;
                    wr_s        = 1'b1;
                end else if (hit_s && rready_cpu) begin
                    state_nxt_s = S_RACK;
                    rd_s        = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RACK:  state_nxt_s = S_IDLE;
            S_WACK:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Counter advance followed by register writes; an mtime write overrides the increment.
    always_comb begin
        mtime_nxt_s    = mtime_r;
        mtimecmp_nxt_s = mtimecmp_r;
        irq_en_nxt_s   = irq_en_r;
        cnt_en_nxt_s   = cnt_en_r;
        prescale_nxt_s = prescale_r;
        pcnt_nxt_s     = pcnt_r;

        if (cnt_en_r) begin
            if (tick_s) begin
                pcnt_nxt_s = 32'd0;
            end else begin
                pcnt_nxt_s = pcnt_r + 32'd1;
            end
        end else begin
            pcnt_nxt_s = pcnt_r;
        end

        if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end

        case (wr_code_s)
            4'd0: mtime_nxt_s = {mtime_r[63:32],
                                 merge_bytes(mtime_r[31:0], data_cpu_o, strb_cpu)};
            4'd1: mtime_nxt_s = {merge_bytes(mtime_r[63:32], data_cpu_o, strb_cpu),
                                 mtime_r[31:0]};
            4'd2: mtimecmp_nxt_s[31:0]  = merge_bytes(mtimecmp_r[31:0], data_cpu_o, strb_cpu);
            4'd3: mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], data_cpu_o, strb_cpu);
            4'd4: begin
                cnt_en_nxt_s = strb_cpu[0] ? data_cpu_o[0] : cnt_en_r;
                irq_en_nxt_s = strb_cpu[0] ? data_cpu_o[1] : irq_en_r;
            end
            4'd5: begin
                prescale_nxt_s = merge_bytes(prescale_r, data_cpu_o, strb_cpu);
                pcnt_nxt_s     = 32'd0;
            end
            default: begin
            end
        endcase
    end

    // Read data mux; the two spare slots read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr_cpu[4:2])
            3'd0:    rd_mux_s = mtime_r[31:0];
            3'd1:    rd_mux_s = mtime_r[63:32];
            3'd2:    rd_mux_s = mtimecmp_r[31:0];
            3'd3:    rd_mux_s = mtimecmp_r[63:32];
            3'd4:    rd_mux_s = {30'd0, irq_en_r, cnt_en_r};
            3'd5:    rd_mux_s = prescale_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // State, timer registers and registered bus/interrupt outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            mtime_r    <= 64'd0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_en_r   <= 1'b0;
            cnt_en_r   <= 1'b1;
            prescale_r <= PRESCALE_RST;
            pcnt_r     <= 32'd0;
            rvalid_r   <= 1'b0;
            wready_r   <= 1'b0;
            rdata_r    <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            cnt_en_r   <= cnt_en_nxt_s;
            prescale_r <= prescale_nxt_s;
            pcnt_r     <= pcnt_nxt_s;
            rvalid_r   <= rd_s;
            wready_r   <= wr_s;
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= rdata_r;
            end
            // Compares the values settled at the previous edge, so it trails them by a cycle.
            irq_r      <= irq_en_r && (mtime_r >= mtimecmp_r);
        end
    end

    assign rvalid_cpu = rvalid_r;
    assign wready_cpu = wready_r;
    assign rdata_cpu  = rdata_r;
    assign timer_irq  = irq_r;

endmodule

// File: tb/tb_rv32_mtimer.sv
// Self-checking bench for rv32_mtimer: directed scenarios plus random register
// traffic, checked against a cycle-level arithmetic model of the timer.
module tb_rv32_mtimer;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rready_cpu = 1'b0, wvalid_cpu = 1'b0;
    logic        rvalid_cpu, wready_cpu, timer_irq;
    logic [3:0]  strb_cpu = 4'h0;
    logic [31:0] addr_cpu = 32'd0, data_cpu_o = 32'd0, rdata_cpu;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] m_time, m_cmp;
    logic        m_irq_en, m_cnt_en, m_irq;
    logic [31:0] m_pre, m_pc;

    rv32_mtimer #(.BASE_ADDR(BASE), .PRESCALE_RST(32'd0)) dut (
        .clk(clk), .rst(rst),
        .rready_cpu(rready_cpu), .rvalid_cpu(rvalid_cpu),
        .wvalid_cpu(wvalid_cpu), .wready_cpu(wready_cpu),
        .strb_cpu(strb_cpu), .addr_cpu(addr_cpu), .data_cpu_o(data_cpu_o),
        .rdata_cpu(rdata_cpu), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bmask(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic [31:0] model_rd(input int idx);
        case (idx)
            0: return m_time[31:0];
            1: return m_time[63:32];
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {30'd0, m_irq_en, m_cnt_en};
            5: return m_pre;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update(input bit wr, input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [63:0] t;
        logic [31:0] pc, c;
        logic        irq_n;
        if (rst) begin
            m_time = 64'd0; m_cmp = '1; m_irq_en = 1'b0; m_cnt_en = 1'b1;
            m_pre = 32'd0; m_pc = 32'd0; m_irq = 1'b0;
        end else begin
            irq_n = m_irq_en && (m_time >= m_cmp);
            t = m_time; pc = m_pc;
            if (m_cnt_en) begin
                if (m_pc == m_pre) begin pc = 32'd0; t = m_time + 64'd1; end
                else pc = m_pc + 32'd1;
            end
            if (wr) begin
                case (idx)
                    0: t = {m_time[63:32], bmask(m_time[31:0], d, s)};
                    1: t = {bmask(m_time[63:32], d, s), m_time[31:0]};
                    2: m_cmp[31:0]  = bmask(m_cmp[31:0], d, s);
                    3: m_cmp[63:32] = bmask(m_cmp[63:32], d, s);
                    4: begin c = bmask({30'd0, m_irq_en, m_cnt_en}, d, s); m_irq_en = c[1]; m_cnt_en = c[0]; end
                    5: begin m_pre = bmask(m_pre, d, s); pc = 32'd0; end
                    default: ;
                endcase
            end
            m_time = t; m_pc = pc; m_irq = irq_n;
        end
    endtask

    task automatic step(input bit wr, input int idx, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk);
        model_update(wr, idx, d, s);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 32'd0, 4'h0);
    endtask

    task automatic bus_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             output logic ack1, output logic ack2, output logic irq1, output logic irq2);
        addr_cpu = BASE + 32'(idx * 4); data_cpu_o = d; strb_cpu = s; wvalid_cpu = 1'b1;
        step(1'b1, idx, d, s);
        ack1 = wready_cpu; irq1 = timer_irq;
        wvalid_cpu = 1'b0;
        step(1'b0, 0, 32'd0, 4'h0);
        ack2 = wready_cpu; irq2 = timer_irq;
    endtask

    task automatic bus_read(input int idx, output logic [31:0] exp, output logic [31:0] got,
                            output logic v1, output logic v2, output logic [31:0] held);
        addr_cpu = BASE + 32'(idx * 4); rready_cpu = 1'b1;
        exp = model_rd(idx);
        step(1'b0, 0, 32'd0, 4'h0);
        v1 = rvalid_cpu; got = rdata_cpu;
        rready_cpu = 1'b0;
        step(1'b0, 0, 32'd0, 4'h0);
        v2 = rvalid_cpu; held = rdata_cpu;
    endtask

    logic        a1, a2, i1, i2, v1, v2;
    logic [31:0] ex, gt, hd;

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_checks += 4;
        if (rvalid_cpu !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=0", rvalid_cpu); end
        if (wready_cpu !== 1'b0) begin n_fail++; $display("FAIL rst_wready got=%b exp=0", wready_cpu); end
        if (rdata_cpu !== 32'd0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rdata_cpu); end
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", timer_irq); end
        rst = 1'b0;
        idle(10);
        bus_read(0, ex, gt, v1, v2, hd);
        n_checks += 6;
        if (gt !== 32'd10) begin n_fail++; $display("FAIL mtime_after_10 got=%0d exp=10", gt); end
        if (gt !== ex) begin n_fail++; $display("FAIL mtime_model got=%h exp=%h", gt, ex); end
        if (v1 !== 1'b1) begin n_fail++; $display("FAIL rvalid_pulse got=%b exp=1", v1); end
        if (v2 !== 1'b0) begin n_fail++; $display("FAIL rvalid_single got=%b exp=0", v2); end
        if (hd !== gt) begin n_fail++; $display("FAIL rdata_hold got=%h exp=%h", hd, gt); end
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_off got=%b exp=0", timer_irq); end
        bus_read(4, ex, gt, v1, v2, hd);
        n_checks += 1;
        if (gt !== 32'd1) begin n_fail++; $display("FAIL ctrl_rst got=%h exp=1", gt); end
        bus_read(3, ex, gt, v1, v2, hd);
        n_checks += 1;
        if (gt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cmp_hi_rst got=%h exp=ffffffff", gt); end
    endtask

    task automatic test_irq();
        int rise_seen;
        rise_seen = 0;
        bus_write(4, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(0, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(1, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(3, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(2, 32'd20, 4'hF, a1, a2, i1, i2);
        n_checks += 2;
        if (a1 !== 1'b1) begin n_fail++; $display("FAIL wready_pulse got=%b exp=1", a1); end
        if (a2 !== 1'b0) begin n_fail++; $display("FAIL wready_single got=%b exp=0", a2); end
        bus_write(4, 32'd3, 4'hF, a1, a2, i1, i2);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 0, 32'd0, 4'h0);
            n_checks++;
            if (timer_irq !== m_irq) begin n_fail++; $display("FAIL irq_track cyc=%0d got=%b exp=%b", i, timer_irq, m_irq); end
            if (m_irq) rise_seen = 1;
        end
        n_checks++;
        if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b exp=1", timer_irq); end
        bus_write(2, 32'd1000, 4'hF, a1, a2, i1, i2);
        n_checks += 2;
        if (i1 !== 1'b1) begin n_fail++; $display("FAIL irq_at_cmp_write got=%b exp=1", i1); end
        if (i2 !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", i2); end
        n_checks++;
        if (rise_seen != 1) begin n_fail++; $display("FAIL model_irq_rise got=%0d exp=1", rise_seen); end
    endtask

    task automatic test_carry();
        bus_write(4, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(5, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(1, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(0, 32'hFFFF_FFFF, 4'hF, a1, a2, i1, i2);
        bus_write(4, 32'd1, 4'hF, a1, a2, i1, i2);
        bus_read(1, ex, gt, v1, v2, hd);
        n_checks += 2;
        if (gt !== 32'd1) begin n_fail++; $display("FAIL carry_hi got=%h exp=1", gt); end
        if (gt !== ex) begin n_fail++; $display("FAIL carry_hi_model got=%h exp=%h", gt, ex); end
        bus_read(0, ex, gt, v1, v2, hd);
        n_checks++;
        if (gt !== ex) begin n_fail++; $display("FAIL carry_lo got=%h exp=%h", gt, ex); end
        bus_write(4, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_write(1, 32'hFFFF_FFFF, 4'hF, a1, a2, i1, i2);
        bus_write(0, 32'hFFFF_FFFF, 4'hF, a1, a2, i1, i2);
        bus_write(4, 32'd1, 4'hF, a1, a2, i1, i2);
        bus_read(1, ex, gt, v1, v2, hd);
        n_checks += 2;
        if (gt !== 32'd0) begin n_fail++; $display("FAIL wrap_hi got=%h exp=0", gt); end
        if (gt !== ex) begin n_fail++; $display("FAIL wrap_hi_model got=%h exp=%h", gt, ex); end
        bus_read(0, ex, gt, v1, v2, hd);
        n_checks++;
        if (gt !== ex) begin n_fail++; $display("FAIL wrap_lo got=%h exp=%h", gt, ex); end
    endtask

    task automatic test_prescale();
        logic [31:0] first;
        int found;
        bus_write(5, 32'd3, 4'hF, a1, a2, i1, i2);
        bus_read(0, ex, gt, v1, v2, hd);
        n_checks++;
        if (gt !== ex) begin n_fail++; $display("FAIL pre_rd0 got=%h exp=%h", gt, ex); end
        first = gt;
        idle(6);
        bus_read(0, ex, gt, v1, v2, hd);
        n_checks += 2;
        if (gt !== ex) begin n_fail++; $display("FAIL pre_rd1 got=%h exp=%h", gt, ex); end
        if (gt - first !== 32'd2) begin n_fail++; $display("FAIL pre_rate got=%0d exp=2", gt - first); end
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            if (m_cnt_en && (m_pc == m_pre)) found = 1;
            else step(1'b0, 0, 32'd0, 4'h0);
        end
        n_checks++;
        if (found != 1) begin n_fail++; $display("FAIL tick_align got=%0d exp=1", found); end
        bus_write(0, 32'h55, 4'hF, a1, a2, i1, i2);
        bus_read(0, ex, gt, v1, v2, hd);
        n_checks += 2;
        if (gt !== 32'h55) begin n_fail++; $display("FAIL wr_vs_inc got=%h exp=00000055", gt); end
        if (gt !== ex) begin n_fail++; $display("FAIL wr_vs_inc_model got=%h exp=%h", gt, ex); end
        bus_write(4, 32'd0, 4'hF, a1, a2, i1, i2);
        bus_read(0, ex, gt, v1, v2, hd);
        first = gt;
        idle(9);
        bus_read(0, ex, gt, v1, v2, hd);
        n_checks += 2;
        if (gt !== first) begin n_fail++; $display("FAIL freeze got=%h exp=%h", gt, first); end
        if (gt !== ex) begin n_fail++; $display("FAIL freeze_model got=%h exp=%h", gt, ex); end
    endtask

    task automatic test_bytes();
        bus_write(2, 32'hFFFF_FFFF, 4'hF, a1, a2, i1, i2);
        bus_write(2, 32'h0000_AB00, 4'b0010, a1, a2, i1, i2);
        bus_read(2, ex, gt, v1, v2, hd);
        n_checks++;
        if (gt !== 32'hFFFF_ABFF) begin n_fail++; $display("FAIL byte_strb got=%h exp=ffffabff", gt); end
        bus_write(4, 32'hFFFF_FFFF, 4'b1110, a1, a2, i1, i2);
        bus_read(4, ex, gt, v1, v2, hd);
        n_checks++;
        if (gt !== 32'd0) begin n_fail++; $display("FAIL ctrl_strb got=%h exp=0", gt); end
        bus_write(6, 32'hDEAD_BEEF, 4'hF, a1, a2, i1, i2);
        n_checks++;
        if (a1 !== 1'b1) begin n_fail++; $display("FAIL spare_wack got=%b exp=1", a1); end
        bus_read(6, ex, gt, v1, v2, hd);
        n_checks += 2;
        if (v1 !== 1'b1) begin n_fail++; $display("FAIL spare_rack got=%b exp=1", v1); end
        if (gt !== 32'd0) begin n_fail++; $display("FAIL spare_rdata got=%h exp=0", gt); end
    endtask

    task automatic test_back_to_back();
        addr_cpu = BASE + 32'h8; data_cpu_o = 32'h1234_5678; strb_cpu = 4'hF;
        wvalid_cpu = 1'b1; rready_cpu = 1'b1;
        step(1'b1, 2, 32'h1234_5678, 4'hF);
        n_checks += 2;
        if (wready_cpu !== 1'b1) begin n_fail++; $display("FAIL b2b_wready got=%b exp=1", wready_cpu); end
        if (rvalid_cpu !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_n1 got=%b exp=0", rvalid_cpu); end
        wvalid_cpu = 1'b0;
        step(1'b0, 0, 32'd0, 4'h0);
        n_checks++;
        if (rvalid_cpu !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_n2 got=%b exp=0", rvalid_cpu); end
        step(1'b0, 0, 32'd0, 4'h0);
        n_checks += 2;
        if (rvalid_cpu !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid_n3 got=%b exp=1", rvalid_cpu); end
        if (rdata_cpu !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_rdata got=%h exp=12345678", rdata_cpu); end
        rready_cpu = 1'b0;
        step(1'b0, 0, 32'd0, 4'h0);
    endtask

    task automatic test_no_hit();
        addr_cpu = BASE + 32'h20; data_cpu_o = 32'h0; strb_cpu = 4'hF;
        rready_cpu = 1'b1; wvalid_cpu = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 32'd0, 4'h0);
            n_checks += 2;
            if (rvalid_cpu !== 1'b0) begin n_fail++; $display("FAIL nohit_rvalid got=%b exp=0", rvalid_cpu); end
            if (wready_cpu !== 1'b0) begin n_fail++; $display("FAIL nohit_wready got=%b exp=0", wready_cpu); end
        end
        rready_cpu = 1'b0; wvalid_cpu = 1'b0;
        bus_read(2, ex, gt, v1, v2, hd);
        n_checks++;
        if (gt !== ex) begin n_fail++; $display("FAIL nohit_unchanged got=%h exp=%h", gt, ex); end
    endtask

    task automatic test_rst_mid();
        addr_cpu = BASE + 32'h10; rready_cpu = 1'b1; rst = 1'b1;
        step(1'b0, 0, 32'd0, 4'h0);
        n_checks++;
        if (rvalid_cpu !== 1'b0) begin n_fail++; $display("FAIL rst_read_rvalid got=%b exp=0", rvalid_cpu); end
        rready_cpu = 1'b0; rst = 1'b0;
        step(1'b0, 0, 32'd0, 4'h0);
        n_checks++;
        if (rvalid_cpu !== 1'b0) begin n_fail++; $display("FAIL rst_read_late got=%b exp=0", rvalid_cpu); end
        addr_cpu = BASE + 32'hC; data_cpu_o = 32'd0; strb_cpu = 4'hF; wvalid_cpu = 1'b1; rst = 1'b1;
        step(1'b0, 0, 32'd0, 4'h0);
        wvalid_cpu = 1'b0; rst = 1'b0;
        step(1'b0, 0, 32'd0, 4'h0);
        n_checks++;
        if (wready_cpu !== 1'b0) begin n_fail++; $display("FAIL rst_write_wready got=%b exp=0", wready_cpu); end
        bus_read(3, ex, gt, v1, v2, hd);
        n_checks++;
        if (gt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_write_lost got=%h exp=ffffffff", gt); end
    endtask

    task automatic test_random();
        int op, idx;
        logic [31:0] d;
        for (int n = 0; n < 80; n++) begin
            op  = $urandom_range(0, 2);
            idx = $urandom_range(0, 7);
            d   = (idx == 5) ? 32'($urandom_range(0, 3)) : $urandom;
            case (op)
                0: begin
                    bus_write(idx, d, 4'($urandom_range(0, 15)), a1, a2, i1, i2);
                    n_checks++;
                    if (a1 !== 1'b1) begin n_fail++; $display("FAIL rnd_wack n=%0d got=%b exp=1", n, a1); end
                end
                1: begin
                    bus_read(idx, ex, gt, v1, v2, hd);
                    n_checks++;
                    if (gt !== ex) begin n_fail++; $display("FAIL rnd_read n=%0d idx=%0d got=%h exp=%h", n, idx, gt, ex); end
                end
                default: idle($urandom_range(1, 3));
            endcase
            n_checks++;
            if (timer_irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, timer_irq, m_irq); end
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_carry();
        test_prescale();
        test_bytes();
        test_back_to_back();
        test_no_hit();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
